seq_merge_4b_5to1: RTL
======================

SEQ_MERGE_4B_5TO1 -- requirements
Module: seq_merge_4b_5to1

Interface
REQ-001: Parameters SHALL be none; all widths are fixed at 4-bit payload, 5 sources and 3-bit source index.
REQ-002: clk  input  1  Sole clock; all state updates on the rising edge.
REQ-003: reset  input  1  Asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004: in0, in1, in2, in3, in4  input  4 each  Payload of source 0..4.
REQ-005: in_val  input  5  Bit i high = source i presents valid payload.
REQ-006: in_rdy  output  5  Bit i high = block accepts source i this cycle; combinational.
REQ-007: out  output  4  Registered merged payload.
REQ-008: out_sel  output  3  Registered index (0..4) of the source that supplied out.
REQ-009: out_val  output  1  Registered; out/out_sel hold a valid item.
REQ-010: out_rdy  input  1  Downstream accepts the item this cycle.

Function
REQ-011: Source transfer SHALL occur when in_val[i] && in_rdy[i]; output transfer SHALL occur when out_val && out_rdy.
REQ-012: The block SHALL hold a single-entry output register; it is free when out_val==0, or when out_val==1 && out_rdy==1 (same-cycle drain and refill).
REQ-013: At most one in_rdy bit SHALL be high per cycle; it SHALL be the arbitration winner, and only while the output register is free.
REQ-014: No in_rdy bit SHALL be high when in_val is all zero or the register is not free.
REQ-015: Arbitration SHALL scan sources starting at priority pointer ptr (3-bit, range 0..4) in ascending order, wrapping 4->0; the first source with in_val high wins.
REQ-016: On a source transfer from source i, ptr SHALL update to (i+1) mod 5 (4 wraps to 0); otherwise ptr SHALL hold.
REQ-017: On a source transfer from source i, the next cycle SHALL show out=in_i as sampled, out_sel=i, out_val=1 (latency 1 cycle).
REQ-018: On an output transfer with no simultaneous source transfer, out_val SHALL go 0 next cycle; out and out_sel SHALL hold their last values.
REQ-019: While out_val==1 && out_rdy==0, out, out_sel and out_val SHALL remain stable.
REQ-020: Sustained throughput SHALL be one item per cycle when out_rdy is held high.
REQ-021: in_rdy SHALL NOT depend combinationally on the in0..in4 payloads.
REQ-022: out_sel SHALL never exceed 4; ptr SHALL never leave 0..4.

Reset
REQ-023: While reset is low: out_val=0, out=4'b0, out_sel=3'd0, ptr=0, in_rdy=5'b0.
REQ-024: Assertion of reset mid-transfer SHALL discard any held item without an output transfer.
REQ-025: After reset deasserts, the first grant SHALL come from the lowest-index valid source.

Configuration
REQ-026: Macro SEQ_MERGE_RR_EN SHALL select the arbitration policy.
REQ-027: With SEQ_MERGE_RR_EN defined, arbitration SHALL be round-robin as in REQ-015/016.
REQ-028: Without SEQ_MERGE_RR_EN, arbitration SHALL be fixed priority: the lowest valid index always wins, ptr is absent, and all other behaviour is unchanged.

Verification
REQ-029: Reset, then in_val=5'b00100, in2=4'hA, out_rdy=1 -> in_rdy=5'b00100; next cycle out=4'hA, out_sel=2, out_val=1.
REQ-030: RR build, in_val=5'b11111 held, out_rdy=1 -> out_sel sequence 0,1,2,3,4,0 on consecutive cycles, out_val constantly 1.
REQ-031: One item held, out_rdy=0 for 3 cycles with in_val=5'b00011 -> in_rdy=0, out/out_sel/out_val stable; out_rdy=1 -> refill from source 1 in the same cycle.
REQ-032: Fixed-priority build, in_val=5'b10001 held, out_rdy=1 -> out_sel stays 0 every cycle; source 4 is never granted.
REQ-033: Last grant from source 4, then in_val=5'b10001 -> pointer wraps and source 0 wins next (out_sel=0).
REQ-034: Reset driven low asynchronously while out_val=1 -> out_val=0, out=0, out_sel=0 before the next clk edge.

Source files
------------

// File: rtl/seq_merge_4b_5to1.sv
// Five-source, 4-bit merge into a single-entry registered output with valid/ready handshakes.
// Arbitration is fixed priority by default; define SEQ_MERGE_RR_EN for round-robin.
module seq_merge_4b_5to1 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] in4,
    input  logic [4:0] in_val,
    output logic [4:0] in_rdy,
    output logic [3:0] out,
    output logic [2:0] out_sel,
    output logic       out_val,
    input  logic       out_rdy
);

    logic       slot_free;
    logic       win_any;
    logic [2:0] win_idx;
    logic [3:0] win_data;

`ifdef SEQ_MERGE_RR_EN
    logic [2:0] ptr;
    logic [2:0] cand;

    // Modulo-5 add for indices already in 0..4.
    function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
    endfunction
`endif

    // The slot may be refilled in the same cycle it drains.
    assign slot_free = !out_val || out_rdy;
    assign win_any   = |in_val;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        win_idx = 3'd0;
`ifdef SEQ_MERGE_RR_EN
        cand = 3'd0;
        // Scan from the farthest offset down so the nearest valid source after ptr wins.
        for (int k = 4; k >= 0; k--) begin
            cand = wrap_add(ptr, 3'(k));
            if (in_val[cand]) win_idx = cand;
        end
`else
        for (int k = 4; k >= 0; k--) begin
            if (in_val[k]) win_idx = 3'(k);
        end
`endif
    end

    always_comb begin
        win_data = 4'd0;
        case (win_idx)
            3'd0:    win_data = in0;
            3'd1:    win_data = in1;
            3'd2:    win_data = in2;
            3'd3:    win_data = in3;
            3'd4:    win_data = in4;
            default: win_data = 4'd0;
        endcase
    end

    // Grant depends only on valids, slot state and ptr, never on payloads.
    assign in_rdy = (reset && slot_free && win_any) ? (5'b00001 << win_idx) : 5'b00000;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out     <= 4'd0;
            out_sel <= 3'd0;
            out_val <= 1'b0;
`ifdef SEQ_MERGE_RR_EN
            ptr     <= 3'd0;
`endif
        end else if (|in_rdy) begin
            out     <= win_data;
            out_sel <= win_idx;
            out_val <= 1'b1;
`ifdef SEQ_MERGE_RR_EN
            ptr     <= wrap_add(win_idx, 3'd1);
`endif
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule
